// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, FSM state encoding and requester-id width
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    localparam int ID_W = 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester ALU request/response bundle
interface alu_arbiter_if;
    import alu_pkg::*;

    logic            req0_valid;
    logic            req1_valid;
    logic            req0_ready;
    logic            req1_ready;
    logic [31:0]     req0_src1;
    logic [31:0]     req0_src2;
    logic [31:0]     req1_src1;
    logic [31:0]     req1_src2;
    logic [3:0]      req0_ctrl;
    logic [3:0]      req1_ctrl;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_zero;
    logic            rsp_cout;
    logic            rsp_overflow;
    logic            rsp_err;

    modport master (
        output req0_valid, req1_valid, req0_src1, req0_src2, req1_src1, req1_src2,
               req0_ctrl, req1_ctrl, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
               rsp_zero, rsp_cout, rsp_overflow, rsp_err
    );

    modport slave (
        input  req0_valid, req1_valid, req0_src1, req0_src2, req1_src1, req1_src2,
               req0_ctrl, req1_ctrl, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
               rsp_zero, rsp_cout, rsp_overflow, rsp_err
    );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with carry/overflow flags and illegal-code error
module alu
    import alu_pkg::*;
(
    input  logic        rst_n,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [3:0]  ctrl_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        cout_o,
    output logic        overflow_o,
    output logic        err_o
);

    logic [32:0] add_w;
    logic [32:0] sub_w;

    // Subtraction as a + ~b + 1 so cout is the "no borrow" carry
    assign add_w = {1'b0, src1_i} + {1'b0, src2_i};
    assign sub_w = {1'b0, src1_i} + {1'b0, ~src2_i} + 33'd1;

    // Operation select; unsupported codes and reset force an all-zero result
    always_comb begin
        result_o   = '0;
        cout_o     = 1'b0;
        overflow_o = 1'b0;
        err_o      = 1'b0;
        case (ctrl_i)
            CTRL_AND: result_o = src1_i & src2_i;
            CTRL_OR:  result_o = src1_i | src2_i;
            CTRL_NOR: result_o = ~(src1_i | src2_i);
            CTRL_SLT: result_o = {31'd0, $signed(src1_i) < $signed(src2_i)};
            CTRL_ADD: begin
                result_o   = add_w[31:0];
                cout_o     = add_w[32];
                overflow_o = (src1_i[31] == src2_i[31]) && (add_w[31] != src1_i[31]);
            end
            CTRL_SUB: begin
                result_o   = sub_w[31:0];
                cout_o     = sub_w[32];
                overflow_o = (src1_i[31] != src2_i[31]) && (sub_w[31] != src1_i[31]);
            end
            default:  err_o = 1'b1;
        endcase
        if (!rst_n) begin
            result_o   = '0;
            cout_o     = 1'b0;
            overflow_o = 1'b0;
            err_o      = 1'b0;
        end
    end

    assign zero_o = rst_n && !err_o && (result_o == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] id_q;
    logic [31:0]     src1_q, src2_q;
    logic [3:0]      ctrl_q;
    logic            accept;

    logic [ID_W-1:0] rsp_id_q;
    logic [31:0]     rsp_result_q;
    logic            rsp_zero_q, rsp_cout_q, rsp_overflow_q, rsp_err_q;

    logic [31:0]     alu_result;
    logic            alu_zero, alu_cout, alu_overflow, alu_err;

    // Round-robin pick: a tie goes to the requester not granted last time
    always_comb begin
        gnt_id = '0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_id = ~last_q;
        end else if (bus.req1_valid) begin
            gnt_id = ID_W'(1);
        end
        accept = rst_n && (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
    end

    assign bus.req0_ready = accept && (gnt_id == ID_W'(0));
    assign bus.req1_ready = accept && (gnt_id == ID_W'(1));

    // Next-state logic for the IDLE -> EXEC -> RESP cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    alu u_alu (
        .rst_n      (rst_n),
        .src1_i     (src1_q),
        .src2_i     (src2_q),
        .ctrl_i     (ctrl_q),
        .result_o   (alu_result),
        .zero_o     (alu_zero),
        .cout_o     (alu_cout),
        .overflow_o (alu_overflow),
        .err_o      (alu_err)
    );

    // State, grant history, operand latch on accept and response capture in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_q         <= ID_W'(1);
            id_q           <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
            ctrl_q         <= '0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_cout_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= gnt_id;
                id_q   <= gnt_id;
                src1_q <= (gnt_id == ID_W'(1)) ? bus.req1_src1 : bus.req0_src1;
                src2_q <= (gnt_id == ID_W'(1)) ? bus.req1_src2 : bus.req0_src2;
                ctrl_q <= (gnt_id == ID_W'(1)) ? bus.req1_ctrl : bus.req0_ctrl;
            end
            if (state_q == ST_EXEC) begin
                rsp_id_q       <= id_q;
                rsp_result_q   <= alu_result;
                rsp_zero_q     <= alu_zero;
                rsp_cout_q     <= alu_cout;
                rsp_overflow_q <= alu_overflow;
                rsp_err_q      <= alu_err;
            end
        end
    end

    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_cout     = rsp_cout_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    function automatic exp_t model(logic id, logic [31:0] a, logic [31:0] b, logic [3:0] ctrl);
        exp_t r;
        logic [32:0] w;
        r = '0;
        r.id = id;
        case (ctrl)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b1100: r.res = ~(a | b);
            4'b0111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0010: begin
                w = {1'b0, a} + {1'b0, b};
                r.res = w[31:0]; r.c = w[32];
                r.o = (a[31] == b[31]) && (w[31] != a[31]);
            end
            4'b0110: begin
                w = {1'b0, a} - {1'b0, b};
                r.res = w[31:0]; r.c = (a >= b);
                r.o = (a[31] != b[31]) && (w[31] != a[31]);
            end
            default: r.e = 1'b1;
        endcase
        r.z = !r.e && (r.res == 32'd0);
        return r;
    endfunction

    function automatic exp_t got_rsp();
        return {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow, bus.rsp_err};
    endfunction

    function automatic exp_t sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_src1 = 0; bus.req0_src2 = 0; bus.req0_ctrl = 0;
        bus.req1_src1 = 0; bus.req1_src2 = 0; bus.req1_ctrl = 0;
        bus.rsp_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl, output bit ok);
        if (id == 1'b0) begin
            bus.req0_valid = 1; bus.req0_src1 = a; bus.req0_src2 = b; bus.req0_ctrl = ctrl;
        end else begin
            bus.req1_valid = 1; bus.req1_src1 = a; bus.req1_src2 = b; bus.req1_ctrl = ctrl;
        end
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
                ok = 1;
                sb.push_back(model(id, a, b, ctrl));
            end
            @(negedge clk);
        end
        if (id == 1'b0) bus.req0_valid = 0; else bus.req1_valid = 0;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        #1;
        while (!bus.rsp_valid && cycles < 20) begin
            @(negedge clk); #1;
            cycles++;
        end
        if (!bus.rsp_valid) cycles = -1;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1;
        @(negedge clk);
        bus.rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1; bus.req1_valid = 1;
        @(negedge clk); #1;
        total++;
        if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000", {bus.rsp_valid, bus.req0_ready, bus.req1_ready});
        end
        total++;
        if (got_rsp() !== exp_t'(0)) begin
            bad++; $display("FAIL reset_rsp got=%h want=0", got_rsp());
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        int gid[$];
        int gcyc[$];
        exp_t e;
        do_reset();
        bus.req0_valid = 1; bus.req0_src1 = 32'd10; bus.req0_src2 = 32'd20; bus.req0_ctrl = CTRL_ADD;
        bus.req1_valid = 1; bus.req1_src1 = 32'd3;  bus.req1_src2 = 32'd7;  bus.req1_ctrl = CTRL_SUB;
        bus.rsp_ready = 1;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) begin
                total++; bad++; $display("FAIL cont_both_ready cycle=%0d", c);
            end
            if (bus.req0_ready) begin gid.push_back(0); gcyc.push_back(c); sb.push_back(model(0, 10, 20, CTRL_ADD)); end
            if (bus.req1_ready) begin gid.push_back(1); gcyc.push_back(c); sb.push_back(model(1, 3, 7, CTRL_SUB)); end
            if (bus.rsp_valid) begin
                e = sb_pop();
                total++;
                if (got_rsp() !== e) begin bad++; $display("FAIL cont_rsp got=%h want=%h", got_rsp(), e); end
            end
            @(negedge clk);
        end
        total++;
        if (gid.size() != 5) begin
            bad++; $display("FAIL cont_grant_count got=%0d want=5", gid.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (gid[i] != (i % 2) || gcyc[i] != 3 * i) begin
                    bad++; $display("FAIL cont_grant%0d got id=%0d cyc=%0d want id=%0d cyc=%0d", i, gid[i], gcyc[i], i % 2, 3 * i);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_single_add();
        bit ok;
        int cyc;
        exp_t e;
        issue(0, 32'h7FFF_FFFF, 32'h0000_0001, CTRL_ADD, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL add_accept got=0 want=1"); end
        wait_rsp(cyc);
        total++;
        if (cyc != 1) begin bad++; $display("FAIL add_latency got=%0d want=1", cyc); end
        total++;
        if (got_rsp() !== {1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL add_const got=%h want=%h", got_rsp(), {1'b0, 32'h8000_0000, 4'b0010});
        end
        e = sb_pop();
        total++;
        if (got_rsp() !== e) begin bad++; $display("FAIL add_sb got=%h want=%h", got_rsp(), e); end
        handshake();
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL add_rsp_drop got=%b want=0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        exp_t e;
        issue(1, 32'd5, 32'd5, CTRL_SUB, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_accept got=0 want=1"); end
        wait_rsp(cyc);
        bus.req0_valid = 1; bus.req0_src1 = 32'd1; bus.req0_src2 = 32'd2; bus.req0_ctrl = CTRL_ADD;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b100 ||
                got_rsp() !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%h want=100/%h", i,
                                {bus.rsp_valid, bus.req0_ready, bus.req1_ready}, got_rsp(), {1'b1, 32'd0, 4'b1100});
            end
            @(negedge clk); #1;
        end
        e = sb_pop();
        total++;
        if (got_rsp() !== e) begin bad++; $display("FAIL bp_sb got=%h want=%h", got_rsp(), e); end
        handshake();
        #1;
        total++;
        if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL bp_pending_grant got=%b want=1", bus.req0_ready); end
        if (bus.req0_ready) sb.push_back(model(0, 1, 2, CTRL_ADD));
        @(negedge clk);
        bus.req0_valid = 0;
        wait_rsp(cyc);
        e = sb_pop();
        total++;
        if (cyc != 1 || got_rsp() !== e) begin bad++; $display("FAIL bp_pending_rsp got=%h want=%h", got_rsp(), e); end
        handshake();
    endtask

    task automatic test_illegal();
        bit ok;
        int cyc;
        exp_t e;
        issue(0, 32'h1234, 32'h5678, 4'b1111, ok);
        wait_rsp(cyc);
        total++;
        if (!ok || cyc != 1 || got_rsp() !== {1'b0, 32'd0, 4'b0001}) begin
            bad++; $display("FAIL illegal_const got=%h want=%h", got_rsp(), {1'b0, 32'd0, 4'b0001});
        end
        e = sb_pop();
        total++;
        if (got_rsp() !== e) begin bad++; $display("FAIL illegal_sb got=%h want=%h", got_rsp(), e); end
        handshake();
        issue(0, 32'hF0, 32'h0F, CTRL_OR, ok);
        wait_rsp(cyc);
        e = sb_pop();
        total++;
        if (!ok || got_rsp() !== e || bus.rsp_err !== 1'b0) begin
            bad++; $display("FAIL illegal_next got=%h want=%h", got_rsp(), e);
        end
        handshake();
    endtask

    task automatic test_slt();
        bit ok;
        int cyc;
        exp_t e;
        issue(1, 32'hFFFF_FFFF, 32'h0000_0001, CTRL_SLT, ok);
        wait_rsp(cyc);
        total++;
        if (!ok || got_rsp() !== {1'b1, 32'd1, 4'b0000}) begin
            bad++; $display("FAIL slt_const got=%h want=%h", got_rsp(), {1'b1, 32'd1, 4'b0000});
        end
        e = sb_pop();
        total++;
        if (got_rsp() !== e) begin bad++; $display("FAIL slt_sb got=%h want=%h", got_rsp(), e); end
        handshake();
    endtask

    task automatic test_reset_resp();
        bit ok;
        int cyc;
        exp_t e;
        issue(0, 32'd3, 32'd4, CTRL_ADD, ok);
        wait_rsp(cyc);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'd0) begin
            bad++; $display("FAIL rst_resp_async got=%b/%h want=0/0", bus.rsp_valid, bus.rsp_result);
        end
        sb.delete();
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_src1 = 32'h0F0F; bus.req0_src2 = 32'h00FF; bus.req0_ctrl = CTRL_AND;
        bus.req1_valid = 1; bus.req1_src1 = 32'd9;    bus.req1_src2 = 32'd9;    bus.req1_ctrl = CTRL_SUB;
        rst_n = 1'b1;
        #1;
        total++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b100) begin
            bad++; $display("FAIL rst_first_tie got=%b want=100", {bus.req0_ready, bus.req1_ready, bus.rsp_valid});
        end
        if (bus.req0_ready) sb.push_back(model(0, 32'h0F0F, 32'h00FF, CTRL_AND));
        @(negedge clk);
        idle_inputs();
        wait_rsp(cyc);
        e = sb_pop();
        total++;
        if (cyc != 1 || got_rsp() !== e) begin bad++; $display("FAIL rst_after_rsp got=%h want=%h", got_rsp(), e); end
        handshake();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_contention();
        test_single_add();
        test_backpressure();
        test_illegal();
        test_slt();
        test_reset_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-004 SHALL have ports req0_ready, req1_ready  output  1 each  operation of requester N accepted this cycle.
REQ-005 SHALL have ports req0_src1, req0_src2, req1_src1, req1_src2  input  32 each  operands.
REQ-006 SHALL have ports req0_ctrl, req1_ctrl  input  4 each  ALU_control code.
REQ-007 SHALL have port rsp_valid  output  1  response held.
REQ-008 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-009 SHALL have port rsp_id  output  1  requester that owns the response.
REQ-010 SHALL have ports rsp_result  output  32, and rsp_zero, rsp_cout, rsp_overflow, rsp_err  output  1 each.

Function
REQ-011 SHALL share one alu instance between two requesters through FSM states IDLE, EXEC, RESP.
REQ-012 In IDLE with at least one valid, SHALL grant one requester, assert only its reqN_ready combinationally that cycle, latch src1/src2/ctrl/id, and go to EXEC.
REQ-013 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-014 The last-grant pointer SHALL update only on an accepted request.
REQ-015 reqN_ready SHALL be 0 in EXEC and RESP; valids arriving then wait, no loss.
REQ-016 In EXEC, SHALL drive the alu from latched operands with rst_n, register result/zero/cout/overflow into the response registers, and go to RESP.
REQ-017 Supported ctrl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; any other code SHALL give rsp_err=1, rsp_result=0, all flags 0.
REQ-018 rsp_zero SHALL equal (rsp_result==0) for supported codes; cout/overflow are meaningful only for ADD/SUB and SHALL be 0 otherwise.
REQ-019 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs stable until rsp_ready=1; on handshake, go to IDLE.
REQ-020 Minimum issue interval SHALL be 3 cycles (accept, EXEC, RESP with immediate rsp_ready); response appears 2 cycles after accept.
REQ-021 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-022 On rst_n=0, SHALL immediately set state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, all rsp flags 0, reqN_ready 0, last-grant pointer 1 (requester 0 wins first tie).
REQ-023 Reset mid-EXEC or mid-RESP SHALL drop the in-flight operation; no response emitted after release.
REQ-024 First grant SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-025 Shared package alu_pkg SHALL hold the six ctrl code constants, the FSM state type and the requester-id width.
REQ-026 The single sub-module SHALL be the existing alu, instantiated once; arbitration and FSM stay in alu_arbiter.

Verification
REQ-027 Single op: req0 ADD 0x7FFFFFFF+0x00000001 -> rsp_id 0, result 0x80000000, overflow 1, cout 0, zero 0, 2 cycles after accept.
REQ-028 Contention: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; each accept 3 cycles apart.
REQ-029 Backpressure: req1 SUB 5-5, rsp_ready low 4 cycles -> rsp_valid held, result 0, zero 1, cout 1, no new ready until handshake.
REQ-030 Illegal code: req0 ctrl 1111 -> rsp_err 1, result 0, flags 0; next legal op unaffected.
REQ-031 Reset during RESP: assert rst_n=0 -> rsp_valid drops asynchronously; after release, first tie grants requester 0.
REQ-032 SLT: req1 src1 0xFFFFFFFF, src2 0x00000001 -> result 0x00000001, zero 0.
